// File: rtl/rotary_pkg.sv
// Shared types for the rotary position/pixel stage: FSM states, the GRB word type and the tail dimmer.
package rotary_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  typedef logic [23:0] grb_t;

  localparam grb_t COLOR_OFF = 24'h00_00_00;

  // Quarter brightness: each colour byte shifted right by two.
  function automatic grb_t dim4(input grb_t c);
    return {2'b00, c[23:18], 2'b00, c[15:10], 2'b00, c[7:2]};
  endfunction

endpackage

// File: rtl/rotary_pos_counter.sv
// Modulo-NUM_LEDS up/down position register with the frame-request (dirty) flag.
// Latency: a strobe in cycle t shows on pos/dirty after edge t+1.
// Backpressure: none; strobes are always absorbed, a set of dirty beats a same-cycle clear.
module rotary_pos_counter
  import rotary_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = $clog2(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_up,
  input  logic             pulse_down,
  input  logic             dirty_clr,
  output logic [IDX_W-1:0] pos,
  output logic             dirty
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  logic step_up;
  logic step_dn;

  // Simultaneous strobes cancel: no move and no new frame.
  assign step_up = pulse_up & ~pulse_down;
  assign step_dn = pulse_down & ~pulse_up;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos   <= '0;
      dirty <= 1'b1;
    end else begin
      if (step_up) begin
        pos <= (pos == LAST_IDX) ? '0 : pos + 1'b1;
      end else if (step_dn) begin
        pos <= (pos == '0) ? LAST_IDX : pos - 1'b1;
      end

      if (step_up | step_dn) begin
        dirty <= 1'b1;
      end else if (dirty_clr) begin
        dirty <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rotary_pixel_fsm.sv
// Streams one GRB frame per position change to the WS2812 serializer, then holds the latch gap (tail pixels: ROTARY_TAIL_EN).
// Latency: strobe in cycle t -> first pixel valid after edge t+2; NUM_LEDS words, LATCH_CYC gap, 1 idle cycle.
// Backpressure: pix_data/pix_last held while pix_valid & !pix_ready; strobes keep updating pos during a frame.
module rotary_pixel_fsm
  import rotary_pkg::*;
#(
  parameter int          NUM_LEDS  = 8,
  parameter int          IDX_W     = $clog2(NUM_LEDS),
  parameter logic [23:0] ON_COLOR  = 24'h10_00_20,
  parameter int          LATCH_CYC = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_up,
  input  logic             pulse_down,
  output logic [23:0]      pix_data,
  output logic             pix_valid,
  output logic             pix_last,
  input  logic             pix_ready,
  output logic [IDX_W-1:0] pos,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(LATCH_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(LATCH_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] snap;
  logic [IDX_W-1:0] snap_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [IDX_W-1:0] idx_inc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  grb_t             pix_data_nxt;
  logic             pix_valid_nxt;
  logic             pix_last_nxt;
  logic             dirty;
  logic             frame_start;
  logic             accept;

  assign accept      = pix_valid & pix_ready;
  assign frame_start = (state == ST_IDLE) & dirty;
  assign idx_inc     = idx + 1'b1;
  assign busy        = (state != ST_IDLE);

  rotary_pos_counter #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_up   (pulse_up),
    .pulse_down (pulse_down),
    .dirty_clr  (frame_start),
    .pos        (pos),
    .dirty      (dirty)
  );

  function automatic grb_t pixel_word(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] s);
`ifdef ROTARY_TAIL_EN
    logic [IDX_W-1:0] s_prev;
    logic [IDX_W-1:0] s_next;
    s_prev = (s == '0) ? LAST_IDX : s - 1'b1;
    s_next = (s == LAST_IDX) ? '0 : s + 1'b1;
    if (i == s) return ON_COLOR;
    if ((i == s_prev) || (i == s_next)) return dim4(ON_COLOR);
    return COLOR_OFF;
`else
    return (i == s) ? ON_COLOR : COLOR_OFF;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      snap      <= '0;
      idx       <= '0;
      cnt       <= '0;
      pix_valid <= 1'b0;
      pix_data  <= COLOR_OFF;
      pix_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      snap      <= snap_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      pix_valid <= pix_valid_nxt;
      pix_data  <= pix_data_nxt;
      pix_last  <= pix_last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (dirty) state_nxt = ST_SEND;
      ST_SEND:  if (accept && pix_last) state_nxt = ST_LATCH;
      ST_LATCH: if (cnt == CNT_END) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output words are registered, so each branch prepares the word visible after the edge.
  always_comb begin
    snap_nxt      = snap;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    pix_valid_nxt = pix_valid;
    pix_data_nxt  = pix_data;
    pix_last_nxt  = pix_last;
    case (state)
      ST_IDLE: begin
        if (dirty) begin
          snap_nxt      = pos;
          idx_nxt       = '0;
          pix_valid_nxt = 1'b1;
          pix_data_nxt  = pixel_word('0, pos);
          pix_last_nxt  = 1'b0;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (pix_last) begin
            pix_valid_nxt = 1'b0;
            pix_data_nxt  = COLOR_OFF;
            pix_last_nxt  = 1'b0;
            cnt_nxt       = '0;
          end else begin
            idx_nxt      = idx_inc;
            pix_data_nxt = pixel_word(idx_inc, snap);
            pix_last_nxt = (idx_inc == LAST_IDX);
          end
        end
      end
      ST_LATCH: begin
        cnt_nxt = cnt + 1'b1;
      end
      default: begin
        pix_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rotary_pixel_fsm.sv
// Directed + randomized bench: a position model built from strobe arithmetic and a frame scoreboard of accepted words.
module tb_rotary_pixel_fsm;

  localparam int          N  = 8;
  localparam int          IW = $clog2(N);
  localparam logic [23:0] ON = 24'h10_00_20;
  localparam int          LC = 5000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pulse_up;
  logic          pulse_down;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          pix_last;
  logic          pix_ready;
  logic [IW-1:0] pos;
  logic          busy;

  always #5 clk = ~clk;

  rotary_pixel_fsm #(
    .NUM_LEDS  (N),
    .IDX_W     (IW),
    .ON_COLOR  (ON),
    .LATCH_CYC (LC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_up   (pulse_up),
    .pulse_down (pulse_down),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .pos        (pos),
    .busy       (busy)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          m_pos;
  int          frames_done;
  int          cur_cyc;
  int          fr_cyc;
  logic [23:0] cur[$];
  logic [23:0] fr[N];
  logic        prev_stall;
  logic [23:0] prev_data;
  logic        prev_last;
  logic        s_valid;
  logic        s_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] exp_word(input int i, input int s);
    int on;
    on = int'(ON);
    if (i == s) return ON;
`ifdef ROTARY_TAIL_EN
    if (i == (s + 1) % N || i == (s + N - 1) % N)
      return 24'((((on >> 16) % 256) / 4) * 65536 + (((on >> 8) % 256) / 4) * 256 + (on % 256) / 4);
`endif
    if (on < 0) return ON;
    return 24'h0;
  endfunction

  // One clock: sample at negedge, check handshake rules, drive inputs, score accepted words.
  task automatic step(input bit up, input bit dn, input int rdy_pct);
    @(negedge clk);
    s_valid = pix_valid;
    s_busy  = busy;
    check("valid_outside_send", 32'(pix_valid & ~busy), 32'd0);
    if (prev_stall) begin
      check("stall_valid", 32'(pix_valid), 32'd1);
      check("stall_data", 32'(pix_data), 32'(prev_data));
      check("stall_last", 32'(pix_last), 32'(prev_last));
    end
    pulse_up   = up;
    pulse_down = dn;
    pix_ready  = (int'($urandom_range(99)) < rdy_pct);
    if (up && !dn) m_pos = (m_pos + 1) % N;
    else if (dn && !up) m_pos = (m_pos + N - 1) % N;
    if (pix_valid) cur_cyc++;
    if (pix_valid && pix_ready) begin
      cur.push_back(pix_data);
      check("last_flag", 32'(pix_last), 32'(cur.size() == N));
      if (pix_last || cur.size() == N) begin
        for (int i = 0; i < N; i++) fr[i] = (i < cur.size()) ? cur[i] : 24'hxxxxxx;
        frames_done++;
        fr_cyc  = cur_cyc;
        cur_cyc = 0;
        cur.delete();
      end
    end
    prev_stall = pix_valid && !pix_ready;
    prev_data  = pix_data;
    prev_last  = pix_last;
  endtask

  task automatic wait_frames(input int target, input int budget, input int rdy);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      step(1'b0, 1'b0, rdy);
      k++;
    end
    check("frame_arrived", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int s);
    for (int i = 0; i < N; i++) check(tag, 32'(fr[i]), 32'(exp_word(i, s)));
  endtask

  task automatic wait_idle(input int budget, output int busy_cyc, output int valid_cyc);
    busy_cyc  = 0;
    valid_cyc = 0;
    for (int k = 0; k < budget; k++) begin
      step(1'b0, 1'b0, 100);
      if (!s_busy) break;
      busy_cyc++;
      if (s_valid) valid_cyc++;
    end
    check("idle_reached", 32'(s_busy), 32'd0);
  endtask

  // Start a frame with one up strobe, then inject strobes while it is being sent.
  task automatic mid_round(input int n_mid, input bit rand_dir, input int rdy);
    int f0, snap0, k, bc, vc;
    bit u, d, changed;
    f0 = frames_done;
    step(1'b1, 1'b0, rdy);
    snap0 = m_pos;
    k = 0;
    while (!s_valid && k < 10) begin
      step(1'b0, 1'b0, rdy);
      k++;
    end
    check("mid_start", 32'(s_valid), 32'd1);
    changed = 1'b0;
    for (int j = 0; j < n_mid; j++) begin
      repeat ($urandom_range(2)) step(1'b0, 1'b0, rdy);
      if (rand_dir) begin
        u = 1'($urandom_range(1));
        d = 1'($urandom_range(1));
        if (!u && !d) u = 1'b1;
      end else begin
        u = 1'b1;
        d = 1'b0;
      end
      if (u != d) changed = 1'b1;
      step(u, d, rdy);
    end
    wait_frames(f0 + 1, 400, rdy);
    check_frame("mid_old_snap", snap0);
    if (changed) begin
      wait_frames(f0 + 2, LC + 400, rdy);
      check_frame("mid_follow_snap", m_pos);
    end
    wait_idle(LC + 20, bc, vc);
    repeat (5) step(1'b0, 1'b0, rdy);
    check("mid_frame_count", 32'(frames_done - f0), changed ? 32'd2 : 32'd1);
    check("mid_pos", 32'(pos), 32'(m_pos));
  endtask

  initial begin
    int bc, vc, f0, snapr, k;
    rst_n = 1'b0; pulse_up = 1'b0; pulse_down = 1'b0; pix_ready = 1'b1;
    m_pos = 0; frames_done = 0; cur_cyc = 0; fr_cyc = 0;
    prev_stall = 1'b0; prev_data = 24'h0; prev_last = 1'b0; s_valid = 1'b0; s_busy = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_last", 32'(pix_last), 32'd0);
    check("rst_pos", 32'(pos), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Frame after reset, one word per cycle, then the latch gap.
    rst_n = 1'b1;
    step(1'b0, 1'b0, 100);
    check("first_valid_latency", 32'(s_valid), 32'd1);
    wait_frames(1, 50, 100);
    check("frame_cycles", 32'(fr_cyc), 32'(N));
    check_frame("reset_frame", 0);
    wait_idle(LC + 20, bc, vc);
    check("latch_busy_cycles", 32'(bc), 32'(LC));
    check("latch_valid", 32'(vc), 32'd0);

    // Down from 0 wraps to N-1, with strobe-to-valid latency of two edges.
    step(1'b0, 1'b1, 100);
    step(1'b0, 1'b0, 100);
    check("pos_down_wrap", 32'(pos), 32'(m_pos));
    check("valid_not_yet", 32'(s_valid), 32'd0);
    step(1'b0, 1'b0, 100);
    check("valid_at_t2", 32'(s_valid), 32'd1);
    wait_frames(2, 50, 100);
    check_frame("down_wrap_frame", 7);
    wait_idle(LC + 20, bc, vc);

    step(1'b1, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    check("pos_up_wrap", 32'(pos), 32'd0);
    wait_frames(3, 50, 100);
    check_frame("up_wrap_frame", 0);
    wait_idle(LC + 20, bc, vc);

    // Three spaced ups: first frame shows 1, single follow-up shows 3.
    step(1'b1, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    step(1'b1, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 100);
    step(1'b1, 1'b0, 100);
    wait_frames(4, 50, 100);
    check_frame("three_up_first", 1);
    wait_frames(5, LC + 100, 100);
    check_frame("three_up_final", 3);
    wait_idle(LC + 20, bc, vc);
    repeat (5) step(1'b0, 1'b0, 100);
    check("three_up_pos", 32'(pos), 32'd3);
    check("three_up_frames", 32'(frames_done), 32'd5);

    // Both strobes together: nothing moves, no frame.
    step(1'b1, 1'b1, 100);
    repeat (10) step(1'b0, 1'b0, 100);
    check("both_pos", 32'(pos), 32'd3);
    check("both_busy", 32'(s_busy), 32'd0);
    check("both_frames", 32'(frames_done), 32'd5);

    // Stalled frame with two mid-frame ups, then randomized rounds.
    mid_round(2, 1'b0, 50);
    for (int r = 0; r < 2; r++) mid_round(int'($urandom_range(1, 3)), 1'b1, int'($urandom_range(30, 90)));

    // Reset while word 4 is on the bus.
    f0 = frames_done;
    step(1'b1, 1'b0, 100);
    snapr = m_pos;
    k = 0;
    while (cur.size() < 4 && k < 20) begin
      step(1'b0, 1'b0, 100);
      k++;
    end
    @(negedge clk);
    check("word4_valid", 32'(pix_valid), 32'd1);
    check("word4_data", 32'(pix_data), 32'(exp_word(4, snapr)));
    rst_n = 1'b0; pix_ready = 1'b0; pulse_up = 1'b0; pulse_down = 1'b0;
    cur.delete(); cur_cyc = 0; prev_stall = 1'b0; m_pos = 0;
    @(negedge clk);
    check("midrst_valid", 32'(pix_valid), 32'd0);
    check("midrst_data", 32'(pix_data), 32'd0);
    check("midrst_last", 32'(pix_last), 32'd0);
    check("midrst_pos", 32'(pos), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    pix_ready = 1'b1;
    wait_frames(f0 + 1, 50, 100);
    check_frame("post_reset_frame", 0);
    wait_idle(LC + 20, bc, vc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rotary_pixel_fsm.md
# rotary_pixel_fsm

Position/pixel stage directly downstream of the rotary decoder. Consumes the single-cycle `pulse_up` / `pulse_down` detent strobes and maintains a wrap-around position over a WS2812 strip. On every position change it streams one full GRB frame, with the pixel at the current position lit, to the WS2812 bit-serializer over a valid/ready pixel handshake. It then enforces the strip latch gap before starting another frame.

## Interface
- `NUM_LEDS`, 8: strip length; ≥ 3.
- `IDX_W`, `$clog2(NUM_LEDS)`: position/index width.
- `ON_COLOR`, 24'h10_00_20: GRB value of the lit pixel.
- `LATCH_CYC`, 5000: idle cycles after the last pixel (50 µs at 100 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  one clock; reset is synchronous and active-low.
- `pulse_up`  in  1  one-cycle CW detent strobe from the decoder.
- `pulse_down`  in  1  one-cycle CCW detent strobe from the decoder.
- `pix_data`  out  24  GRB pixel word, registered.
- `pix_valid`  out  1  pixel word valid, registered.
- `pix_last`  out  1  marks pixel `NUM_LEDS-1` of the frame.
- `pix_ready`  in  1  serializer accepts the word on `pix_valid & pix_ready`.
- `pos`  out  IDX_W  current position, for debug.
- `busy`  out  1  high in SEND or LATCH.

## Operation
- Position register `pos`:
  - `pulse_up` only: `pos+1`; wraps from `NUM_LEDS-1` to 0.
  - `pulse_down` only: `pos-1`; wraps from 0 to `NUM_LEDS-1`.
  - Both strobes in the same cycle: no change, `dirty` not set.
- `dirty` flag:
  - Set on every `pos` change.
  - Set by reset, so a frame goes out after reset.
  - Cleared when a frame starts.
  - If a set and a clear fall on the same cycle, the set wins.
- FSM states: IDLE, SEND, LATCH.
  - IDLE: if `dirty`, then `snap <= pos`, `idx <= 0`, clear `dirty`, go to SEND.
  - SEND: `pix_valid=1`. `pix_data = (idx==snap) ? ON_COLOR : 0`. `pix_last = (idx==NUM_LEDS-1)`. On handshake, if `pix_last` go to LATCH with `cnt <= 0`; otherwise `idx <= idx+1` and load the next word.
  - LATCH: `cnt` increments; at `cnt==LATCH_CYC-1`, go to IDLE.
- A frame always shows `snap`. Strobes during SEND or LATCH update `pos` and `dirty` immediately. Any number of mid-frame changes produces exactly one follow-up frame, which shows the final `pos`.
- Handshake rules:
  - `pix_data` and `pix_last` are held stable while `pix_valid & !pix_ready`.
  - `pix_valid` is never dropped before acceptance.
  - `pix_valid` is never high outside SEND.

## Timing
- Reset values: `pix_valid=0`, `pix_data=0`, `pix_last=0`, `pos=0`, `busy=0`, state IDLE, `dirty=1`, `idx=0`, `cnt=0`.
- Strobe in cycle t → `pos` and `dirty` update at edge t+1 → SEND entered at edge t+2 with `pix_valid` high, if the FSM was idle.
- With `pix_ready` held high: one pixel per cycle. A frame occupies `NUM_LEDS` cycles, followed by `LATCH_CYC` LATCH cycles and 1 IDLE cycle.
- `rst_n` low during SEND or LATCH: all outputs reach their reset values at the next edge. The partial frame is abandoned. After release, a fresh frame showing position 0 is sent.

## Configuration
- `ROTARY_TAIL_EN`:
  - Defined: the pixels at `(snap-1)` and `(snap+1)`, both modulo `NUM_LEDS`, carry `ON_COLOR` with each byte shifted right by 2. `snap` itself keeps the full `ON_COLOR`.
  - Undefined: only the `snap` pixel is lit and all other pixels are 0. No tail logic is synthesized.

## Structure
- Package `rotary_pkg`:
  - State enum (`ST_IDLE`, `ST_SEND`, `ST_LATCH`).
  - `grb_t` (24-bit) typedef and `COLOR_OFF`.
  - `dim4()` function (per-byte `>>2`) used by the tail.
- Sub-module `rotary_pos_counter`: the modulo-`NUM_LEDS` up/down `pos` register plus the `dirty` set/clear logic. The FSM, the pixel generator and the latch counter stay in the top module.

## Test plan
- Release reset with `pix_ready=1` → 8 words; word 0 = 24'h100020, words 1–7 = 0, `pix_last` on word 7. Then `busy` stays high for 5000 cycles and `pix_valid` stays 0.
- Three spaced `pulse_up` → `pos=3`; the final frame has only word 3 = `ON_COLOR`.
- `pulse_down` at `pos=0` → `pos=7`, word 7 lit; then `pulse_up` → `pos=0`.
- `pulse_up` and `pulse_down` in the same cycle while idle → `pos` unchanged and no frame is started.
- `pix_ready` random 50% with two `pulse_up` strobes mid-frame:
  - Words stay stable while stalled.
  - The current frame still shows the old `snap`.
  - Exactly one extra frame follows, showing `snap+2`.
- Reset asserted on word 4 of SEND → `pix_valid=0` at the next edge. After release, a frame with word 0 lit. With `ROTARY_TAIL_EN` defined, words 7 and 1 = 24'h040008.
